// File: rtl/suppression_valve_scheduler.sv
// Shares one suppression valve between four alarm channels: latches alarm pulses, fires one owner for ON_CYCLES, then cools for COOL_CYCLES.
// Define SCHED_RR_EN for round-robin owner selection; left undefined, channel 0 has fixed highest priority.
module suppression_valve_scheduler #(
    parameter int ON_CYCLES   = 100,
    parameter int COOL_CYCLES = 20,
    parameter int CW          = 16
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [3:0] Req,
    input  logic       Abort,
    output logic [3:0] Grant,
    output logic       ValveOn,
    output logic       Busy,
    output logic [3:0] Pending
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIRE = 2'd1,
        COOL = 2'd2
    } state_t;

    localparam logic [CW-1:0] ON_LOAD   = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] COOL_LOAD = CW'(COOL_CYCLES - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    last_q, last_d;
    logic [3:0]    pend_q, pend_d;
    logic [3:0]    grant_q, grant_d;
    logic          valve_q, valve_d;
    logic          busy_q, busy_d;
    logic [3:0]    clr;
    logic [1:0]    sel;
    logic          sel_vld;
`ifdef SCHED_RR_EN
    logic [1:0]    idx;
`endif

    // Descending scan so the candidate nearest the search start is the one left standing.
    always_comb begin
        sel     = 2'd0;
        sel_vld = 1'b0;
`ifdef SCHED_RR_EN
        idx     = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            idx = last_q + 2'(k + 1);
            if (pend_q[idx]) begin
                sel     = idx;
                sel_vld = 1'b1;
            end
        end
`else
        for (int k = 3; k >= 0; k--) begin
            if (pend_q[2'(k)]) begin
                sel     = 2'(k);
                sel_vld = 1'b1;
            end
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        grant_d = grant_q;
        valve_d = valve_q;
        busy_d  = busy_q;
        clr     = 4'b0000;
        case (state_q)
            IDLE: begin
                if (sel_vld) begin
                    state_d = FIRE;
                    grant_d = 4'b0001 << sel;
                    valve_d = 1'b1;
                    busy_d  = 1'b1;
                    cnt_d   = ON_LOAD;
                    clr     = 4'b0001 << sel;
                    last_d  = sel;
                end
            end
            FIRE: begin
                if (Abort || cnt_q == '0) begin
                    state_d = COOL;
                    grant_d = 4'b0000;
                    valve_d = 1'b0;
                    cnt_d   = COOL_LOAD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            COOL: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 4'b0000;
                valve_d = 1'b0;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
        // A re-request landing on the same edge as its grant stays pending.
        pend_d = (pend_q & ~clr) | Req;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 2'd3;
            pend_q  <= 4'b0000;
            grant_q <= 4'b0000;
            valve_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            pend_q  <= pend_d;
            grant_q <= grant_d;
            valve_q <= valve_d;
            busy_q  <= busy_d;
        end
    end

    assign Grant   = grant_q;
    assign ValveOn = valve_q;
    assign Busy    = busy_q;
    assign Pending = pend_q;

endmodule
